// File: rtl/mux2to1.sv
// 2:1 mux with a combinational output, an enable-gated registered copy and an optional
// saturating sel-transition counter (built only when MUX2TO1_STATS_EN is defined).
module mux2to1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_q_valid
`ifdef MUX2TO1_STATS_EN
  ,
  output logic [CNT_W-1:0] sel_changes
`endif
);

  // The parameters are only legal within these ranges.
  // CNT_W matters only when the counter is built.
  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 2 || CNT_W > 32) begin : g_param_range_illegal
  end

  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] r_out_q;
  logic             r_out_q_valid;

  // An unknown sel falls through to in0 rather than propagating X.
  always_comb begin
    w_out = in0;
    if (sel == 1'b1) begin
      w_out = in1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_q       <= '0;
      r_out_q_valid <= 1'b0;
    end else if (en) begin
      r_out_q       <= w_out;
      r_out_q_valid <= 1'b1;
    end else begin
      r_out_q_valid <= 1'b0;
    end
  end

  assign out         = w_out;
  assign out_q       = r_out_q;
  assign out_q_valid = r_out_q_valid;

`ifdef MUX2TO1_STATS_EN
  logic             r_sel_prev;
  logic             r_sel_loaded;
  logic [CNT_W-1:0] r_sel_changes;

  // The first edge after reset only loads r_sel_prev, so it never counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_prev    <= 1'b0;
      r_sel_loaded  <= 1'b0;
      r_sel_changes <= '0;
    end else begin
      r_sel_prev   <= sel;
      r_sel_loaded <= 1'b1;
      if (r_sel_loaded && (sel != r_sel_prev) && (r_sel_changes != {CNT_W{1'b1}})) begin
        r_sel_changes <= r_sel_changes + 1'b1;
      end
    end
  end

  assign sel_changes = r_sel_changes;
`endif

endmodule

// File: tb/tb_mux2to1.sv
// Directed testbench for mux2to1 (WIDTH=8, CNT_W=2); the counter checks run only
// when MUX2TO1_STATS_EN is defined.
module tb_mux2to1;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_q_valid;
`ifdef MUX2TO1_STATS_EN
  logic [CNT_W-1:0] sel_changes;
`endif

  int n_tests;
  int n_failed;

  mux2to1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in0        (in0),
    .in1        (in1),
    .sel        (sel),
    .en         (en),
    .out        (out),
    .out_q      (out_q),
    .out_q_valid(out_q_valid)
`ifdef MUX2TO1_STATS_EN
    ,
    .sel_changes(sel_changes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_tests++;
    if (observed !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end else begin
      $display("[TB] ok   %s: %0h", tag, observed);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after an edge.
  task automatic at_negedge();
    @(negedge clk);
  endtask

  task automatic after_posedge();
    @(posedge clk);
    #1;
  endtask

  // Truth table vectors: {sel, in0, in1, expected out}
  logic [3:0] tt_vec [6];
  logic [3:0] v;
`ifdef MUX2TO1_STATS_EN
  logic [CNT_W-1:0] cnt_exp [6];
`endif

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 1'b0;
    in0   = '0;
    in1   = '0;

    tt_vec[0] = 4'b0000;
    tt_vec[1] = 4'b0101;
    tt_vec[2] = 4'b0010;
    tt_vec[3] = 4'b1011;
    tt_vec[4] = 4'b1100;
    tt_vec[5] = 4'b1111;

    // Combinational truth table, 10 ns per vector, while held in reset
    for (int i = 0; i < 6; i++) begin
      at_negedge();
      v   = tt_vec[i];
      sel = v[3];
      in0 = {7'd0, v[2]};
      in1 = {7'd0, v[1]};
      #1;
      check_eq($sformatf("truth_table[%0d]", i), 64'(out), {63'd0, v[0]});
    end

    // Reset for two edges
    at_negedge();
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_out_q", 64'(out_q), 64'h0);
    check_eq("reset_valid", 64'(out_q_valid), 64'h0);
`ifdef MUX2TO1_STATS_EN
    check_eq("reset_sel_changes", 64'(sel_changes), 64'h0);
`endif

    // Release, capture in1=1 after one edge
    at_negedge();
    rst_n = 1'b1;
    en    = 1'b1;
    sel   = 1'b1;
    in0   = 8'h00;
    in1   = 8'h01;
    #1;
    check_eq("pre_edge_out_q", 64'(out_q), 64'h0);
    after_posedge();
    check_eq("capture_out_q", 64'(out_q), 64'h1);
    check_eq("capture_valid", 64'(out_q_valid), 64'h1);

    // Hold with en=0; out follows the new select immediately
    at_negedge();
    en  = 1'b0;
    sel = 1'b0;
    in0 = 8'h00;
    #1;
    check_eq("hold_out_comb", 64'(out), 64'h0);
    after_posedge();
    check_eq("hold_out_q", 64'(out_q), 64'h1);
    check_eq("hold_valid", 64'(out_q_valid), 64'h0);

    // Inputs changing between edges: only the value present at the edge is taken
    at_negedge();
    en  = 1'b1;
    in0 = 8'hFF;
    #1;
    check_eq("between_edges_out_q", 64'(out_q), 64'h1);
    #2;
    in0 = 8'h11;
    after_posedge();
    check_eq("edge_value_out_q", 64'(out_q), 64'h11);

    // Width test
    at_negedge();
    in0 = 8'hA5;
    in1 = 8'h3C;
    sel = 1'b0;
    #1;
    check_eq("width_out_sel0", 64'(out), 64'hA5);
    after_posedge();
    check_eq("width_out_q_sel0", 64'(out_q), 64'hA5);
    at_negedge();
    sel = 1'b1;
    #1;
    check_eq("width_out_sel1", 64'(out), 64'h3C);
    check_eq("width_out_q_lag", 64'(out_q), 64'hA5);
    after_posedge();
    check_eq("width_out_q_sel1", 64'(out_q), 64'h3C);
    check_eq("width_valid", 64'(out_q_valid), 64'h1);

    // Counter: one reset edge, then sel toggles every edge for 6 edges with en=0
    at_negedge();
    rst_n = 1'b0;
    sel   = 1'b0;
    after_posedge();
    at_negedge();
    rst_n = 1'b1;
    en    = 1'b0;
`ifdef MUX2TO1_STATS_EN
    cnt_exp[0] = 2'd0;
    cnt_exp[1] = 2'd1;
    cnt_exp[2] = 2'd2;
    cnt_exp[3] = 2'd3;
    cnt_exp[4] = 2'd3;
    cnt_exp[5] = 2'd3;
`endif
    for (int e = 0; e < 6; e++) begin
      if (e > 0) begin
        at_negedge();
        sel = ~sel;
      end
      after_posedge();
`ifdef MUX2TO1_STATS_EN
      check_eq($sformatf("sel_changes[%0d]", e), 64'(sel_changes), 64'(cnt_exp[e]));
`endif
    end
    check_eq("counter_phase_valid", 64'(out_q_valid), 64'h0);
    check_eq("counter_phase_out_q", 64'(out_q), 64'h0);

    // Reset mid-operation: capture a 1, then reset for one edge with en=1
    at_negedge();
    en  = 1'b1;
    sel = 1'b1;
    in1 = 8'h01;
    after_posedge();
    check_eq("midop_pre_out_q", 64'(out_q), 64'h1);
    at_negedge();
    rst_n = 1'b0;
    #1;
    check_eq("midop_out_comb", 64'(out), 64'h1);
    after_posedge();
    check_eq("midop_reset_out_q", 64'(out_q), 64'h0);
    check_eq("midop_reset_valid", 64'(out_q_valid), 64'h0);
    check_eq("midop_reset_out", 64'(out), 64'h1);
`ifdef MUX2TO1_STATS_EN
    check_eq("midop_reset_sel_changes", 64'(sel_changes), 64'h0);
`endif
    at_negedge();
    rst_n = 1'b1;
    after_posedge();
    check_eq("post_reset_out_q", 64'(out_q), 64'h1);
    check_eq("post_reset_valid", 64'(out_q_valid), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
